fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0200, giving the first fetch address after reset.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving queue entries; legal values are powers of two, 2 to 16.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-005 The block SHALL have port imemreq_val, output, 1, fetch request valid.
REQ-006 The block SHALL have port imemreq_addr, output, 32, fetch byte address.
REQ-007 The block SHALL have port imemresp_data, input, 32, instruction word, valid in the same cycle as imemreq_val.
REQ-008 The block SHALL have port redirect_val, input, 1, control-flow redirect request.
REQ-009 The block SHALL have port redirect_pc, input, 32, redirect target address.
REQ-010 The block SHALL have port inst_val, output, 1, head instruction valid to decode.
REQ-011 The block SHALL have port inst_rdy, input, 1, decode accepts the head instruction.
REQ-012 The block SHALL have port inst, output, 32, head instruction word.
REQ-013 The block SHALL have port inst_pc, output, 32, address of the head instruction.

Function
REQ-014 State SHALL be: fetch PC register, DEPTH-entry circular buffer of {inst, pc}, head and tail pointers wrapping modulo DEPTH, and a count from 0 to DEPTH.
REQ-015 imemreq_val SHALL equal !rst && !redirect_val && (count < DEPTH); imemreq_addr SHALL equal the fetch PC register.
REQ-016 Fetch SHALL happen when imemreq_val is high: imemresp_data and imemreq_addr are written at tail on the clock edge, tail advances, and fetch PC becomes fetch PC + 4 modulo 2^32.
REQ-017 A dequeue slot freed in the same cycle SHALL NOT enable a fetch when count == DEPTH; a full queue does not fetch.
REQ-018 inst_val SHALL equal (count != 0) && !redirect_val; inst and inst_pc SHALL be driven combinationally from the head entry.
REQ-019 Dequeue SHALL happen when inst_val && inst_rdy: head advances by one.
REQ-020 A fetch and a dequeue in the same cycle SHALL leave count unchanged; a fetch alone increments count and a dequeue alone decrements it.
REQ-021 A redirect_val cycle SHALL take priority over every other event: no fetch, no dequeue, and all entries are discarded.
REQ-022 After a redirect_val cycle, count, head and tail SHALL be 0 and fetch PC SHALL equal redirect_pc.
REQ-023 Consecutive redirect cycles SHALL take the last redirect_pc.
REQ-024 Fetch-to-decode latency SHALL be one cycle: an instruction fetched in cycle N is presented with inst_val high in cycle N+1, given no redirect.
REQ-025 inst and inst_pc SHALL hold stable while inst_val is high and inst_rdy is low.
REQ-026 When inst_val is low, the values of inst and inst_pc SHALL be don't-care.

Reset
REQ-027 When rst is high, count, head and tail SHALL become 0 and fetch PC SHALL become RESET_PC at the next edge.
REQ-028 While rst is high, imemreq_val and inst_val SHALL be 0; rst overrides redirect_val.
REQ-029 Reset asserted mid-operation SHALL discard all queued entries, with no dequeue in the reset cycle.
REQ-030 The first fetch after reset SHALL occur in the first cycle with rst low, at address RESET_PC.

Verification
REQ-031 The bench SHALL cover: rst for 2 cycles, then released -> cycle 0 imemreq_val=1, imemreq_addr=0x200; cycle 1 inst_val=1, inst_pc=0x200.
REQ-032 The bench SHALL cover: inst_rdy=0 held after reset -> fetches at 0x200, 0x204, 0x208, 0x20C, then imemreq_val=0 with count=4; inst_pc stays at 0x200.
REQ-033 The bench SHALL cover: inst_rdy=1 throughout -> one instruction per cycle with inst_pc 0x200, 0x204, 0x208..., and inst matching the memory words.
REQ-034 The bench SHALL cover: full queue, then redirect_val=1 with redirect_pc=0x300 for one cycle -> in that cycle inst_val=0 and imemreq_val=0; next cycle imemreq_addr=0x300; following cycle inst_pc=0x300.
REQ-035 The bench SHALL cover: redirect to 0xFFFFFFFC with inst_rdy=1 -> fetches at 0xFFFFFFFC then 0x00000000; inst_pc sequence matches.
REQ-036 The bench SHALL cover: rst asserted for one cycle with 3 entries queued -> next cycle inst_val=0, then fetch restarts at 0x200.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction fetch queue: sequential PC fetch into a circular buffer,
// presenting the oldest entry to decode, with redirect and reset flush.
module fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0200,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imemreq_val,
    output logic [31:0] imemreq_addr,
    input  logic [31:0] imemresp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_pc,
    output logic        inst_val,
    input  logic        inst_rdy,
    output logic [31:0] inst,
    output logic [31:0] inst_pc
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [PW-1:0] PTR_ONE  = PW'(1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    entry_t        buf_q [DEPTH];
    entry_t        head_e;

    logic [31:0]   fetch_pc_q;
    logic [31:0]   fetch_pc_d;
    logic [PW-1:0] head_q;
    logic [PW-1:0] head_d;
    logic [PW-1:0] tail_q;
    logic [PW-1:0] tail_d;
    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    logic          full;
    logic          empty;
    logic          fetch;
    logic          deq;

    assign full  = (count_q == CNT_FULL);
    assign empty = (count_q == '0);

    // A slot freed by this cycle's dequeue never enables a fetch.
    assign imemreq_val  = !rst && !redirect_val && !full;
    assign imemreq_addr = fetch_pc_q;

    assign inst_val = !rst && !redirect_val && !empty;
    assign head_e   = buf_q[head_q];
    assign inst     = head_e.inst;
    assign inst_pc  = head_e.pc;

    assign fetch = imemreq_val;
    assign deq   = inst_val && inst_rdy;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;

        if (rst) begin
            fetch_pc_d = RESET_PC;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else if (redirect_val) begin
            fetch_pc_d = redirect_pc;
            head_d     = '0;
            tail_d     = '0;
            count_d    = '0;
        end else begin
            if (fetch) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                tail_d     = tail_q + PTR_ONE;
            end
            if (deq) begin
                head_d = head_q + PTR_ONE;
            end
            unique case ({fetch, deq})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        fetch_pc_q <= fetch_pc_d;
        head_q     <= head_d;
        tail_q     <= tail_d;
        count_q    <= count_d;
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (fetch) begin
            buf_q[tail_q] <= '{inst: imemresp_data, pc: fetch_pc_q};
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue.
// Memory is a fixed address-to-word function.
module tb_fetch_queue;

    logic        clk;
    logic        rst;
    logic        imemreq_val;
    logic [31:0] imemreq_addr;
    logic [31:0] imemresp_data;
    logic        redirect_val;
    logic [31:0] redirect_pc;
    logic        inst_val;
    logic        inst_rdy;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    int checks = 0;
    int passes = 0;

    fetch_queue #(
        .RESET_PC(32'h0000_0200),
        .DEPTH   (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .imemreq_val  (imemreq_val),
        .imemreq_addr (imemreq_addr),
        .imemresp_data(imemresp_data),
        .redirect_val (redirect_val),
        .redirect_pc  (redirect_pc),
        .inst_val     (inst_val),
        .inst_rdy     (inst_rdy),
        .inst         (inst),
        .inst_pc      (inst_pc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC0DE, a[31:16] ^ 16'h1234};
    endfunction

    assign imemresp_data = mem_word(imemreq_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_val = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        redirect_val = 1'b0;
        inst_rdy = 1'b0;
        tick();
        checks++;
        if (imemreq_val !== 1'b0)
            $display("FAIL rst_reqval: got %b want 0", imemreq_val);
        else passes++;
        checks++;
        if (inst_val !== 1'b0)
            $display("FAIL rst_instval: got %b want 0", inst_val);
        else passes++;
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (imemreq_val !== 1'b1 || imemreq_addr !== 32'h200)
            $display("FAIL rel_c0_req: got %b/%h want 1/00000200",
                     imemreq_val, imemreq_addr);
        else passes++;
        checks++;
        if (inst_val !== 1'b0)
            $display("FAIL rel_c0_instval: got %b want 0", inst_val);
        else passes++;
        tick();
        checks++;
        if (inst_val !== 1'b1 || inst_pc !== 32'h200)
            $display("FAIL rel_c1_inst: got %b/%h want 1/00000200",
                     inst_val, inst_pc);
        else passes++;
        checks++;
        if (inst !== mem_word(32'h200))
            $display("FAIL rel_c1_word: got %h want %h",
                     inst, mem_word(32'h200));
        else passes++;
    endtask

    task automatic test_fill();
        logic [31:0] exp_addr;
        inst_rdy = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            exp_addr = 32'h200 + 32'(4 * i);
            checks++;
            if (imemreq_val !== 1'b1 || imemreq_addr !== exp_addr)
                $display("FAIL fill_req%0d: got %b/%h want 1/%h",
                         i, imemreq_val, imemreq_addr, exp_addr);
            else passes++;
            if (i > 0) begin
                checks++;
                if (inst_val !== 1'b1 || inst_pc !== 32'h200)
                    $display("FAIL fill_hold%0d: got %b/%h want 1/00000200",
                             i, inst_val, inst_pc);
                else passes++;
            end
            tick();
        end
        checks++;
        if (imemreq_val !== 1'b0)
            $display("FAIL fill_full: got %b want 0", imemreq_val);
        else passes++;
        checks++;
        if (inst_val !== 1'b1 || inst_pc !== 32'h200)
            $display("FAIL fill_head: got %b/%h want 1/00000200",
                     inst_val, inst_pc);
        else passes++;
        inst_rdy = 1'b1;
        #1;
        checks++;
        if (imemreq_val !== 1'b0)
            $display("FAIL full_deq_nofetch: got %b want 0", imemreq_val);
        else passes++;
        tick();
        inst_rdy = 1'b0;
        #1;
        checks++;
        if (imemreq_val !== 1'b1 || imemreq_addr !== 32'h210)
            $display("FAIL after_deq_req: got %b/%h want 1/00000210",
                     imemreq_val, imemreq_addr);
        else passes++;
        checks++;
        if (inst_pc !== 32'h204 || inst !== mem_word(32'h204))
            $display("FAIL after_deq_head: got %h/%h want 00000204/%h",
                     inst_pc, inst, mem_word(32'h204));
        else passes++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        inst_rdy = 1'b1;
        do_reset();
        checks++;
        if (inst_val !== 1'b0)
            $display("FAIL stream_c0: got %b want 0", inst_val);
        else passes++;
        for (int k = 1; k <= 6; k++) begin
            tick();
            exp_pc = 32'h200 + 32'(4 * (k - 1));
            checks++;
            if (inst_val !== 1'b1 || inst_pc !== exp_pc
                || inst !== mem_word(exp_pc))
                $display("FAIL stream%0d: got %b/%h/%h want 1/%h/%h",
                         k, inst_val, inst_pc, inst, exp_pc,
                         mem_word(exp_pc));
            else passes++;
        end
        inst_rdy = 1'b0;
    endtask

    task automatic test_redirect();
        inst_rdy = 1'b0;
        do_reset();
        repeat (4) tick();
        checks++;
        if (imemreq_val !== 1'b0)
            $display("FAIL redir_prefull: got %b want 0", imemreq_val);
        else passes++;
        redirect_val = 1'b1;
        redirect_pc = 32'h300;
        inst_rdy = 1'b1;
        #1;
        checks++;
        if (inst_val !== 1'b0 || imemreq_val !== 1'b0)
            $display("FAIL redir_cycle: got %b/%b want 0/0",
                     inst_val, imemreq_val);
        else passes++;
        tick();
        redirect_val = 1'b0;
        #1;
        checks++;
        if (imemreq_val !== 1'b1 || imemreq_addr !== 32'h300)
            $display("FAIL redir_req: got %b/%h want 1/00000300",
                     imemreq_val, imemreq_addr);
        else passes++;
        checks++;
        if (inst_val !== 1'b0)
            $display("FAIL redir_flushed: got %b want 0", inst_val);
        else passes++;
        tick();
        checks++;
        if (inst_val !== 1'b1 || inst_pc !== 32'h300
            || inst !== mem_word(32'h300))
            $display("FAIL redir_head: got %b/%h/%h want 1/00000300/%h",
                     inst_val, inst_pc, inst, mem_word(32'h300));
        else passes++;
        redirect_val = 1'b1;
        redirect_pc = 32'h400;
        tick();
        redirect_pc = 32'h500;
        tick();
        redirect_val = 1'b0;
        #1;
        checks++;
        if (imemreq_addr !== 32'h500 || inst_val !== 1'b0)
            $display("FAIL redir_last: got %h/%b want 00000500/0",
                     imemreq_addr, inst_val);
        else passes++;
        inst_rdy = 1'b0;
    endtask

    task automatic test_wrap();
        inst_rdy = 1'b1;
        do_reset();
        redirect_val = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_val = 1'b0;
        #1;
        checks++;
        if (imemreq_val !== 1'b1 || imemreq_addr !== 32'hFFFF_FFFC)
            $display("FAIL wrap_req0: got %b/%h want 1/fffffffc",
                     imemreq_val, imemreq_addr);
        else passes++;
        tick();
        checks++;
        if (imemreq_addr !== 32'h0)
            $display("FAIL wrap_req1: got %h want 00000000", imemreq_addr);
        else passes++;
        checks++;
        if (inst_val !== 1'b1 || inst_pc !== 32'hFFFF_FFFC
            || inst !== mem_word(32'hFFFF_FFFC))
            $display("FAIL wrap_inst0: got %b/%h/%h want 1/fffffffc/%h",
                     inst_val, inst_pc, inst, mem_word(32'hFFFF_FFFC));
        else passes++;
        tick();
        checks++;
        if (inst_val !== 1'b1 || inst_pc !== 32'h0 || imemreq_addr !== 32'h4)
            $display("FAIL wrap_inst1: got %b/%h/%h want 1/00000000/00000004",
                     inst_val, inst_pc, imemreq_addr);
        else passes++;
        inst_rdy = 1'b0;
    endtask

    task automatic test_mid_reset();
        inst_rdy = 1'b0;
        do_reset();
        repeat (3) tick();
        checks++;
        if (imemreq_addr !== 32'h20C || inst_val !== 1'b1)
            $display("FAIL mid_pre: got %h/%b want 0000020c/1",
                     imemreq_addr, inst_val);
        else passes++;
        rst = 1'b1;
        redirect_val = 1'b1;
        redirect_pc = 32'h700;
        inst_rdy = 1'b1;
        #1;
        checks++;
        if (inst_val !== 1'b0 || imemreq_val !== 1'b0)
            $display("FAIL mid_rstcycle: got %b/%b want 0/0",
                     inst_val, imemreq_val);
        else passes++;
        tick();
        rst = 1'b0;
        redirect_val = 1'b0;
        inst_rdy = 1'b0;
        #1;
        checks++;
        if (inst_val !== 1'b0)
            $display("FAIL mid_flushed: got %b want 0", inst_val);
        else passes++;
        checks++;
        if (imemreq_val !== 1'b1 || imemreq_addr !== 32'h200)
            $display("FAIL mid_restart: got %b/%h want 1/00000200",
                     imemreq_val, imemreq_addr);
        else passes++;
        tick();
        checks++;
        if (inst_val !== 1'b1 || inst_pc !== 32'h200)
            $display("FAIL mid_head: got %b/%h want 1/00000200",
                     inst_val, inst_pc);
        else passes++;
    endtask

    initial begin
        rst = 1'b1;
        redirect_val = 1'b0;
        redirect_pc = 32'h0;
        inst_rdy = 1'b0;
        test_reset();
        test_fill();
        test_stream();
        test_redirect();
        test_wrap();
        test_mid_reset();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
